uart_rib_master: RTL and testbench

- Byte-stream debug/download bridge: acts as a RIB bus master (same role as the JTAG master port) driven by commands from a UART receiver byte stream.
- Parses write/read command frames, performs one 32-bit RIB access per frame, and returns a response byte stream for the UART transmitter.
- Connects to a free master port of the RIB interconnect (m2-style signals).
- Used for loading RAM and peeking peripherals without JTAG.

---
 rtl/uart_rib_master.sv | 190 +++++++++++++++++++
 tb/tb_uart_rib_master.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rib_master.sv
// UART byte-stream to RIB bus master bridge: parses write/read frames, performs one 32-bit access per frame.
// Optional trailing XOR checksum byte when UART_RIB_CHECKSUM_EN is defined.
module uart_rib_master #(
  parameter int         BUS_TIMEOUT = 1000,
  parameter logic [7:0] CMD_WRITE   = 8'hA5,
  parameter logic [7:0] CMD_READ    = 8'h5A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i,
  output logic        mem_we_o,
  output logic        mem_req_o,
  input  logic        mem_ack_i,
  output logic        busy_o
);

`ifdef UART_RIB_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_CSUM, S_BUS, S_RESP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;
`endif

  localparam logic [15:0] TMO_LIMIT = BUS_TIMEOUT[15:0];

  state_t      state_q;
  logic        we_q;
  logic [1:0]  cnt_q;
  logic [1:0]  idx_q;
  logic [1:0]  last_q;
  logic [15:0] tmo_q;
  logic [31:0] addr_sh_q, data_sh_q, rdata_q;
  logic [31:0] addr_d, data_d;
  logic [31:0] mem_addr_q, mem_data_q;
  logic        mem_req_q, mem_we_q;
  logic [7:0]  tx_data_q, nxt_byte_d;
  logic        tx_valid_q;
`ifdef UART_RIB_CHECKSUM_EN
  logic [7:0]  xor_q;
`endif

  // Field bytes arrive little-endian, so shift in from the top.
  always_comb begin
    addr_d = addr_sh_q;
    data_d = data_sh_q;
    if (rx_valid_i && state_q == S_ADDR) addr_d = {rx_data_i, addr_sh_q[31:8]};
    if (rx_valid_i && state_q == S_DATA) data_d = {rx_data_i, data_sh_q[31:8]};
  end

  always_comb begin
    nxt_byte_d = rdata_q[15:8];
    case (idx_q)
      2'd0:    nxt_byte_d = rdata_q[15:8];
      2'd1:    nxt_byte_d = rdata_q[23:16];
      default: nxt_byte_d = rdata_q[31:24];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      cnt_q      <= '0;
      idx_q      <= '0;
      last_q     <= '0;
      tmo_q      <= '0;
      addr_sh_q  <= '0;
      data_sh_q  <= '0;
      rdata_q    <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
`ifdef UART_RIB_CHECKSUM_EN
      xor_q      <= '0;
`endif
    end else begin
      addr_sh_q <= addr_d;
      data_sh_q <= data_d;
      case (state_q)
        S_IDLE: if (rx_valid_i) begin
          if (rx_data_i == CMD_WRITE || rx_data_i == CMD_READ) begin
            we_q    <= (rx_data_i == CMD_WRITE);
            cnt_q   <= '0;
            state_q <= S_ADDR;
`ifdef UART_RIB_CHECKSUM_EN
            xor_q   <= rx_data_i;
`endif
          end else begin
            tx_data_q  <= 8'hEE;
            tx_valid_q <= 1'b1;
            idx_q      <= '0;
            last_q     <= '0;
            state_q    <= S_RESP;
          end
        end
        S_ADDR, S_DATA: if (rx_valid_i) begin
          cnt_q <= cnt_q + 2'd1;
`ifdef UART_RIB_CHECKSUM_EN
          xor_q <= xor_q ^ rx_data_i;
`endif
          if (cnt_q == 2'd3) begin
            if (state_q == S_ADDR && we_q) begin
              state_q <= S_DATA;
            end else begin
`ifdef UART_RIB_CHECKSUM_EN
              state_q <= S_CSUM;
`else
              state_q    <= S_BUS;
              mem_req_q  <= 1'b1;
              mem_we_q   <= we_q;
              mem_addr_q <= addr_d;
              if (we_q) mem_data_q <= data_d;
              tmo_q      <= '0;
`endif
            end
          end
        end
`ifdef UART_RIB_CHECKSUM_EN
        S_CSUM: if (rx_valid_i) begin
          if (rx_data_i == xor_q) begin
            state_q    <= S_BUS;
            mem_req_q  <= 1'b1;
            mem_we_q   <= we_q;
            mem_addr_q <= addr_sh_q;
            if (we_q) mem_data_q <= data_sh_q;
            tmo_q      <= '0;
          end else begin
            tx_data_q  <= 8'hEE;
            tx_valid_q <= 1'b1;
            idx_q      <= '0;
            last_q     <= '0;
            state_q    <= S_RESP;
          end
        end
`endif
        S_BUS: begin
          // Ack wins over a timeout landing on the same cycle.
          if (mem_ack_i) begin
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            rdata_q    <= mem_data_i;
            tx_data_q  <= we_q ? 8'hAA : mem_data_i[7:0];
            last_q     <= we_q ? 2'd0 : 2'd3;
            idx_q      <= '0;
            tx_valid_q <= 1'b1;
            state_q    <= S_RESP;
          end else if (tmo_q + 16'd1 == TMO_LIMIT) begin
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            tx_data_q  <= 8'hEE;
            last_q     <= '0;
            idx_q      <= '0;
            tx_valid_q <= 1'b1;
            state_q    <= S_RESP;
          end else begin
            tmo_q <= tmo_q + 16'd1;
          end
        end
        S_RESP: if (tx_ready_i) begin
          if (idx_q == last_q) begin
            tx_valid_q <= 1'b0;
            state_q    <= S_IDLE;
          end else begin
            idx_q     <= idx_q + 2'd1;
            tx_data_q <= nxt_byte_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_data_o = mem_data_q;
  assign mem_we_o   = mem_we_q;
  assign mem_req_o  = mem_req_q;
  assign busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rib_master.sv
// Directed self-checking bench for uart_rib_master (BUS_TIMEOUT=16).
// Frames carry a checksum byte when UART_RIB_CHECKSUM_EN is defined.
module tb_uart_rib_master;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data_i = '0;
  logic        rx_valid_i = 1'b0;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i = 1'b0;
  logic [31:0] mem_addr_o, mem_data_o;
  logic [31:0] mem_data_i = '0;
  logic        mem_we_o, mem_req_o;
  logic        mem_ack_i = 1'b0;
  logic        busy_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  uart_rib_master #(.BUS_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
    .mem_we_o(mem_we_o), .mem_req_o(mem_req_o), .mem_ack_i(mem_ack_i),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else pass_cnt++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    @(negedge clk);
    rx_valid_i = 1'b0;
  endtask

  task automatic send_frame(input bit wr, input logic [31:0] a, input logic [31:0] d);
    logic [7:0] x;
    x = wr ? 8'hA5 : 8'h5A;
    send_byte(x);
    for (int i = 0; i < 4; i++) begin
      send_byte(a[8*i +: 8]);
      x = x ^ a[8*i +: 8];
    end
    if (wr) begin
      for (int i = 0; i < 4; i++) begin
        send_byte(d[8*i +: 8]);
        x = x ^ d[8*i +: 8];
      end
    end
`ifdef UART_RIB_CHECKSUM_EN
    send_byte(x);
`endif
  endtask

  task automatic accept_byte(input string nm, input logic [7:0] exp);
    int n;
    n = 0;
    while (!tx_valid_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    total_cnt++;
    if (tx_valid_o !== 1'b1) $display("FAIL %s: tx_valid timeout got %b expected 1", nm, tx_valid_o);
    else pass_cnt++;
    total_cnt++;
    if (tx_data_o !== exp) $display("FAIL %s: tx_data got %h expected %h", nm, tx_data_o, exp);
    else pass_cnt++;
    tx_ready_i = 1'b1;
    @(negedge clk);
    tx_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    check("rst_req", {31'd0, mem_req_o}, 32'd0);
    check("rst_we", {31'd0, mem_we_o}, 32'd0);
    check("rst_txv", {31'd0, tx_valid_o}, 32'd0);
    check("rst_txd", {24'd0, tx_data_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_addr", mem_addr_o, 32'd0);
    check("rst_data", mem_data_o, 32'd0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write();
    send_frame(1'b1, 32'h1000_0000, 32'h1234_5678);
    check("wr_req_latency", {31'd0, mem_req_o}, 32'd1);
    check("wr_we", {31'd0, mem_we_o}, 32'd1);
    check("wr_addr", mem_addr_o, 32'h1000_0000);
    check("wr_data", mem_data_o, 32'h1234_5678);
    send_byte(8'h5A);
    check("wr_rx_drop_req", {31'd0, mem_req_o}, 32'd1);
    check("wr_rx_drop_txv", {31'd0, tx_valid_o}, 32'd0);
    @(negedge clk);
    check("wr_req_hold", {31'd0, mem_req_o}, 32'd1);
    mem_ack_i = 1'b1;
    @(negedge clk);
    mem_ack_i = 1'b0;
    check("wr_req_drop", {31'd0, mem_req_o}, 32'd0);
    check("wr_we_drop", {31'd0, mem_we_o}, 32'd0);
    check("wr_txv_latency", {31'd0, tx_valid_o}, 32'd1);
    check("wr_addr_keep", mem_addr_o, 32'h1000_0000);
    accept_byte("wr_resp", 8'hAA);
    check("wr_txv_end", {31'd0, tx_valid_o}, 32'd0);
    check("wr_busy_end", {31'd0, busy_o}, 32'd0);
  endtask

  task automatic test_read();
    logic [31:0] rd;
    rd = 32'hDEAD_BEEF;
    send_frame(1'b0, 32'h1000_0004, 32'd0);
    check("rd_req", {31'd0, mem_req_o}, 32'd1);
    check("rd_we", {31'd0, mem_we_o}, 32'd0);
    check("rd_addr", mem_addr_o, 32'h1000_0004);
    mem_data_i = rd;
    mem_ack_i  = 1'b1;
    @(negedge clk);
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    check("rd_req_drop", {31'd0, mem_req_o}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("rd_txv", {31'd0, tx_valid_o}, 32'd1);
      check("rd_byte", {24'd0, tx_data_o}, {24'd0, rd[8*i +: 8]});
      tx_ready_i = 1'b0;
      @(negedge clk);
      check("rd_byte_stable", {24'd0, tx_data_o}, {24'd0, rd[8*i +: 8]});
      tx_ready_i = 1'b1;
      @(negedge clk);
      tx_ready_i = 1'b0;
    end
    check("rd_txv_end", {31'd0, tx_valid_o}, 32'd0);
    check("rd_busy_end", {31'd0, busy_o}, 32'd0);
    check("rd_wdata_keep", mem_data_o, 32'h1234_5678);
  endtask

  task automatic test_unknown();
    send_byte(8'h33);
    check("unk_req", {31'd0, mem_req_o}, 32'd0);
    check("unk_busy", {31'd0, busy_o}, 32'd1);
    accept_byte("unk_resp", 8'hEE);
    check("unk_idle", {31'd0, busy_o}, 32'd0);
    send_frame(1'b1, 32'h0000_0100, 32'hCAFE_F00D);
    check("unk_next_addr", mem_addr_o, 32'h0000_0100);
    check("unk_next_data", mem_data_o, 32'hCAFE_F00D);
    mem_ack_i = 1'b1;
    @(negedge clk);
    mem_ack_i = 1'b0;
    accept_byte("unk_next_resp", 8'hAA);
  endtask

  task automatic test_timeout();
    int n;
    send_frame(1'b0, 32'h2000_0000, 32'd0);
    n = 0;
    while (mem_req_o && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("tmo_req_cycles", n, 32'd16);
    check("tmo_req_low", {31'd0, mem_req_o}, 32'd0);
    accept_byte("tmo_resp", 8'hEE);
    check("tmo_busy_end", {31'd0, busy_o}, 32'd0);
  endtask

  task automatic test_reset_mid_frame();
    send_byte(8'hA5);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    check("mid_rst_req", {31'd0, mem_req_o}, 32'd0);
    send_frame(1'b1, 32'h3000_0020, 32'h89AB_CDEF);
    check("mid_rst_addr", mem_addr_o, 32'h3000_0020);
    check("mid_rst_data", mem_data_o, 32'h89AB_CDEF);
    check("mid_rst_req2", {31'd0, mem_req_o}, 32'd1);
    mem_ack_i = 1'b1;
    @(negedge clk);
    mem_ack_i = 1'b0;
    accept_byte("mid_rst_resp", 8'hAA);
  endtask

`ifdef UART_RIB_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] good [10];
    good = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h10, 8'h01, 8'h00, 8'h00, 8'h00, 8'hB4};
    for (int i = 0; i < 10; i++) send_byte(good[i]);
    check("cs_good_req", {31'd0, mem_req_o}, 32'd1);
    check("cs_good_data", mem_data_o, 32'h0000_0001);
    mem_ack_i = 1'b1;
    @(negedge clk);
    mem_ack_i = 1'b0;
    accept_byte("cs_good_resp", 8'hAA);
    for (int i = 0; i < 9; i++) send_byte(good[i]);
    send_byte(8'h00);
    check("cs_bad_req", {31'd0, mem_req_o}, 32'd0);
    accept_byte("cs_bad_resp", 8'hEE);
    check("cs_bad_busy", {31'd0, busy_o}, 32'd0);
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_unknown();
    test_timeout();
    test_reset_mid_frame();
`ifdef UART_RIB_CHECKSUM_EN
    test_checksum();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
